// File: rtl/tpu_mmio_sequencer.sv
// tpu_mmio_sequencer: turns a host stream of A/B rows into TPU MMIO writes,
// fires MatMul, waits out the array latency, then streams the C words back.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data/in_valid/in_ready      host word stream (A rows then B rows)
//   out_data/out_valid/out_ready   C word stream back to the host
//   tpu_addr/tpu_wdata/tpu_r_w     registered MMIO command bus
//   tpu_rdata                      MMIO read data (combinational from tpu_addr)
//   busy, done                     op in flight / one-cycle completion pulse
//   perf_cycles                    busy-cycle counter, only with TPU_SEQ_PERF_EN
//
// Build option: define TPU_SEQ_PERF_EN to add the perf_cycles output.

module tpu_mmio_sequencer #(
   parameter int DIM         = 8,
   parameter int DATAW       = 64,
   parameter int ADDRW       = 16,
   parameter int CALC_CYCLES = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DATAW-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_wdata,
   output logic             tpu_r_w,
   input  logic [DATAW-1:0] tpu_rdata,
   output logic             busy,
   output logic             done
`ifdef TPU_SEQ_PERF_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int WCW = $clog2(2*DIM);
   localparam int TCW = $clog2(CALC_CYCLES+1);

   localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
   localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
   localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
   localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

   typedef enum logic [2:0] {
      S_LOAD_A,
      S_LOAD_B,
      S_START,
      S_WAIT,
      S_READ_C
   } state_t;

   state_t           r_state;
   logic [WCW-1:0]   r_wcnt;
   logic [WCW-1:0]   r_rcnt;
   logic [TCW-1:0]   r_tcnt;
   logic             r_rd_all;
   logic             r_in_ready;
   logic [DATAW-1:0] r_out_data;
   logic             r_out_valid;
   logic [ADDRW-1:0] r_addr;
   logic [DATAW-1:0] r_wdata;
   logic             r_rw;
   logic             r_busy;
   logic             r_done;

   logic w_accept;
   logic w_load_last;
   logic w_rd_last;
   logic w_out_take;
   logic w_capture;
   logic w_final;

   assign w_accept    = in_valid & r_in_ready;
   assign w_load_last = (r_wcnt == WCW'(DIM-1));
   assign w_rd_last   = (r_rcnt == WCW'(2*DIM-1));
   assign w_out_take  = r_out_valid & out_ready;

   // The output register refills whenever it is empty or being drained.
   assign w_capture = (r_state == S_READ_C) & ~r_rd_all &
                      (~r_out_valid | out_ready);

   // Once all C words are captured, the held word is the last one.
   assign w_final = (r_state == S_READ_C) & r_rd_all & w_out_take;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_LOAD_A;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_tcnt      <= '0;
         r_rd_all    <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rw        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_rw   <= 1'b0;
         unique case (r_state)
            S_LOAD_A: begin
               if (w_accept) begin
                  r_addr  <= A_BASE + (ADDRW'(r_wcnt) << 3);
                  r_wdata <= in_data;
                  r_rw    <= 1'b1;
                  r_busy  <= 1'b1;
                  if (w_load_last) begin
                     r_wcnt  <= '0;
                     r_state <= S_LOAD_B;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            S_LOAD_B: begin
               if (w_accept) begin
                  r_addr  <= B_BASE + (ADDRW'(r_wcnt) << 3);
                  r_wdata <= in_data;
                  r_rw    <= 1'b1;
                  if (w_load_last) begin
                     r_wcnt     <= '0;
                     r_in_ready <= 1'b0;
                     r_state    <= S_START;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            S_START: begin
               r_addr  <= MM_ADDR;
               r_wdata <= '0;
               r_rw    <= 1'b1;
               r_tcnt  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Bus idles at address 0 for CALC_CYCLES cycles,
               // then the first C read address goes out.
               if (r_tcnt == TCW'(CALC_CYCLES)) begin
                  r_tcnt   <= '0;
                  r_rcnt   <= '0;
                  r_rd_all <= 1'b0;
                  r_addr   <= C_BASE;
                  r_state  <= S_READ_C;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
                  r_addr <= '0;
               end
            end
            S_READ_C: begin
               if (w_final) begin
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_rcnt      <= '0;
                  r_wcnt      <= '0;
                  r_tcnt      <= '0;
                  r_rd_all    <= 1'b0;
                  r_state     <= S_LOAD_A;
               end else begin
                  if (w_out_take) begin
                     r_out_valid <= 1'b0;
                  end
                  if (w_capture) begin
                     r_out_data  <= tpu_rdata;
                     r_out_valid <= 1'b1;
                     if (w_rd_last) begin
                        r_rd_all <= 1'b1;
                     end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                        r_addr <= r_addr + ADDRW'(8);
                     end
                  end
               end
            end
            default: begin
               r_state <= S_LOAD_A;
            end
         endcase
      end
   end

`ifdef TPU_SEQ_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf <= '0;
      end else if ((r_state == S_LOAD_A) && w_accept && (r_wcnt == '0)) begin
         r_perf <= '0;
      end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_cycles = r_perf;
`endif

   assign in_ready  = r_in_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign tpu_addr  = r_addr;
   assign tpu_wdata = r_wdata;
   assign tpu_r_w   = r_rw;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_tpu_mmio_sequencer.sv
// tb_tpu_mmio_sequencer: scoreboard bench for tpu_mmio_sequencer.
// Expected MMIO writes and C words are queued by stimulus, popped by a monitor.

module tb_tpu_mmio_sequencer;

   localparam int DIM   = 8;
   localparam int DATAW = 64;
   localparam int ADDRW = 16;
   localparam int CALC  = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic [DATAW-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [DATAW-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [ADDRW-1:0] tpu_addr;
   logic [DATAW-1:0] tpu_wdata;
   logic             tpu_r_w;
   logic [DATAW-1:0] tpu_rdata;
   logic             busy;
   logic             done;
`ifdef TPU_SEQ_PERF_EN
   logic [31:0]      perf_cycles;
`endif

   logic [7:0] op_tag;

   always #5 clk = ~clk;

   // Fake TPU: C read data encodes the op tag and the address read.
   assign tpu_rdata = {8'hC0, op_tag, 32'h0, tpu_addr};

   tpu_mmio_sequencer #(
      .DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .CALC_CYCLES(CALC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .tpu_addr(tpu_addr),
      .tpu_wdata(tpu_wdata),
      .tpu_r_w(tpu_r_w),
      .tpu_rdata(tpu_rdata),
      .busy(busy),
      .done(done)
`ifdef TPU_SEQ_PERF_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   typedef struct {
      logic [15:0] addr;
      logic [63:0] data;
      int          cyc;
   } wr_t;

   wr_t         wq[$];
   logic [63:0] oq[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int mm_cyc = 0;
   int rd0_cyc = 0;

   function automatic logic [63:0] a_word(int tag, int k);
      return {16'h0101, 8'(tag), 32'h0101_0101, 8'(k)};
   endfunction

   function automatic logic [63:0] b_word(int tag, int k);
      return {16'h0202, 8'(tag), 32'h0202_0202, 8'(k)};
   endfunction

   function automatic logic [63:0] c_word(int tag, int j);
      return {8'hC0, 8'(tag), 32'h0, 16'h0300 + 16'(8*j)};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin : mon
      wr_t e;
      if (!rst) begin
         if (done) done_cnt++;
         if (tpu_r_w) begin
            if (wq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %h want none",
                        tpu_addr);
            end else begin
               e = wq.pop_front();
               check("wr_addr", 64'(tpu_addr), 64'(e.addr));
               check("wr_data", tpu_wdata, e.data);
               check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (tpu_addr == 16'h0400) mm_cyc = cyc;
         end else if (tpu_addr == 16'h0300 && rd0_cyc < mm_cyc) begin
            rd0_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (oq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: got %h want none", out_data);
            end else begin
               check("out_word", out_data, oq.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(logic [63:0] d, logic [15:0] a);
      int w = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && w < 300) begin
         tick();
         w++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got in_ready 0 want 1");
         in_valid = 1'b0;
      end else begin
         // After a stall, ready must reopen exactly with the done pulse.
         if (w > 0) check("ready_at_done", 64'(done), 64'd1);
         wq.push_back('{addr: a, data: d, cyc: cyc + 1});
         tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic load(int tag, bit gap, bit abort_b4);
      for (int k = 0; k < DIM; k++) begin
         send_word(a_word(tag, k), 16'h0100 + 16'(8*k));
         if (k == 0) begin
            op_tag = 8'(tag);
            check("busy_after_accept", 64'(busy), 64'd1);
         end
         if (gap) tick();
      end
      for (int k = 0; k < DIM; k++) begin
         if (abort_b4 && k == 4) return;
         send_word(b_word(tag, k), 16'h0200 + 16'(8*k));
         if (k == DIM-1) begin
            wq.push_back('{addr: 16'h0400, data: 64'h0, cyc: cyc + 1});
            for (int j = 0; j < 2*DIM; j++) oq.push_back(c_word(tag, j));
         end
         if (gap) tick();
      end
   endtask

   task automatic drain(int tag, bit bp, bit chk_q);
      int w = 0;
      int d0 = done_cnt;
      bit bp_done = 1'b0;
      while (!done && w < 400) begin
         if (bp && !bp_done && out_valid && tpu_addr == 16'h0318) begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               check("bp_data", out_data, c_word(tag, 2));
               check("bp_valid", 64'(out_valid), 64'd1);
               check("bp_addr", 64'(tpu_addr), 64'h0318);
               tick();
            end
            out_ready = 1'b1;
            bp_done = 1'b1;
         end else begin
            tick();
            w++;
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got done 0 want 1");
         return;
      end
      check("busy_at_done", 64'(busy), 64'd0);
      check("ready_after_done", 64'(in_ready), 64'd1);
      check("valid_after_done", 64'(out_valid), 64'd0);
      check("wait_span", 64'(rd0_cyc - mm_cyc), 64'(CALC + 1));
`ifdef TPU_SEQ_PERF_EN
      if (!bp) begin
         check("perf_cycles", 64'(perf_cycles), 64'(16 + 1 + CALC + 16 + 1));
         repeat (3) tick();
         check("perf_frozen", 64'(perf_cycles), 64'(16 + 1 + CALC + 16 + 1));
      end
`endif
      tick();
      tick();
      if (chk_q) begin
         check("done_pulses", 64'(done_cnt - d0), 64'd1);
         check("wq_empty", 64'(wq.size()), 64'd0);
         check("oq_empty", 64'(oq.size()), 64'd0);
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      wq.delete();
      oq.delete();
      tick();
      in_valid = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_addr", 64'(tpu_addr), 64'd0);
      check("rst_wdata", tpu_wdata, 64'd0);
      check("rst_r_w", 64'(tpu_r_w), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();
      check("post_rst_r_w", 64'(tpu_r_w), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_tag    = 8'h00;
      tick();
      reset_pulse();
      tick();

      // Stall-free op.
      load(1, 1'b0, 1'b0);
      drain(1, 1'b0, 1'b1);

      // Host gaps between every word.
      load(2, 1'b1, 1'b0);
      drain(2, 1'b0, 1'b1);

      // Output backpressure at j=3.
      load(3, 1'b0, 1'b0);
      drain(3, 1'b1, 1'b1);

      // Reset during WAIT, then a clean op.
      load(4, 1'b0, 1'b0);
      repeat (10) tick();
      check("wait_busy", 64'(busy), 64'd1);
      check("wait_addr", 64'(tpu_addr), 64'd0);
      reset_pulse();
      repeat (40) tick();
      load(5, 1'b0, 1'b0);
      drain(5, 1'b0, 1'b1);

      // Reset while B word 4 is offered, then a clean op.
      load(6, 1'b0, 1'b1);
      tick();
      in_data  = b_word(6, 4);
      in_valid = 1'b1;
      reset_pulse();
      repeat (40) tick();
      load(7, 1'b0, 1'b0);
      drain(7, 1'b0, 1'b1);

      // Second op offered while the first drains.
      load(8, 1'b0, 1'b0);
      fork
         drain(8, 1'b0, 1'b0);
         begin
            repeat (30) tick();
            load(9, 1'b0, 1'b0);
         end
      join
      drain(9, 1'b0, 1'b1);

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
